// File: rtl/clkdiv_pkg.sv
// Shared mode encodings and sizing helper for the multi-channel clock divider.
// Mode value 2'b11 is reserved and behaves as HALT inside each channel.
package clkdiv_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HALT = 2'b00;
   localparam mode_t MODE_RUN  = 2'b01;
   localparam mode_t MODE_STEP = 2'b10;

   function automatic int ch_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: divisor/mode registers, up-counter with terminal compare,
// registered tick and divided clock.
//
// mode      | meaning
// ----------+----------------------------------------------------------
// MODE_HALT | counter and divided clock frozen, tick low, step ignored
// MODE_RUN  | free-running: tick every div cycles, div_clk toggles on tick
// MODE_STEP | idle at cnt==0; a step starts one div-cycle count ending in one tick
// 2'b11     | reserved, behaves as MODE_HALT
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int DIV_RST = 2500
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   input  mode_t            wr_mode,
   input  logic             step,
   output logic             tick,
   output logic             div_clk,
   output logic             busy
);

   mode_t            mode;
   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] cnt;
   logic             at_term;
   logic             advance;

   // div==0 is excluded by advance, so the wrapped div-1 never matches here
   assign at_term = (cnt == (div - CNT_W'(1)));

   assign advance = (div != '0) &&
                    ((mode == MODE_RUN) ||
                     ((mode == MODE_STEP) && ((cnt != '0) || step)));

   assign busy = (cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div     <= CNT_W'(DIV_RST);
         mode    <= MODE_RUN;
         cnt     <= '0;
         tick    <= 1'b0;
         div_clk <= 1'b0;
      end else if (wr) begin
         // A write overrides any terminal count or step arriving on the same edge
         div  <= wr_div;
         mode <= wr_mode;
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (div == '0) begin
            cnt <= '0;
         end else if (advance) begin
            if (at_term) begin
               cnt     <= '0;
               tick    <= 1'b1;
               div_clk <= ~div_clk;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/clkdiv_multi.sv
// NCH independent clock dividers sharing one configuration write port.
// Reset assertion is immediate; release reaches the channels through a two-flop synchroniser.
module clkdiv_multi
   import clkdiv_pkg::*;
#(
   parameter  int NCH     = 2,
   parameter  int CNT_W   = 16,
   parameter  int DIV_RST = 2500,
   localparam int CH_W    = ch_width(NCH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr,
   input  logic [CH_W-1:0]  i_ch,
   input  logic [CNT_W-1:0] i_div,
   input  logic [1:0]       i_mode,
   input  logic [NCH-1:0]   i_step,
   output logic [NCH-1:0]   o_tick,
   output logic [NCH-1:0]   o_clk,
   output logic [NCH-1:0]   o_busy
);

   logic [1:0] rst_sync;
   logic       rst_chan_n;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_chan_n = rst_sync[1];

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      logic wr_hit;

      // Channel numbers >= NCH never match, so such writes are dropped
      assign wr_hit = i_wr && (i_ch == CH_W'(g));

      clkdiv_chan #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_RST)
      ) u_chan (
         .clk     (i_clk),
         .rst_n   (rst_chan_n),
         .wr      (wr_hit),
         .wr_div  (i_div),
         .wr_mode (i_mode),
         .step    (i_step[g]),
         .tick    (o_tick[g]),
         .div_clk (o_clk[g]),
         .busy    (o_busy[g])
      );
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: directed reset/run/step/write-collision sequences,
// a configuration table, and a randomized run against an arithmetic reference model.
module tb_clkdiv_multi;
   import clkdiv_pkg::*;

   localparam int NCH     = 3;
   localparam int CNT_W   = 16;
   localparam int DIV_RST = 2500;
   localparam int CH_W    = 2;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_wr;
   logic [CH_W-1:0]  i_ch;
   logic [CNT_W-1:0] i_div;
   logic [1:0]       i_mode;
   logic [NCH-1:0]   i_step;
   logic [NCH-1:0]   o_tick;
   logic [NCH-1:0]   o_clk;
   logic [NCH-1:0]   o_busy;

   int errors = 0;
   int checks = 0;
   int cyc;

   clkdiv_multi #(
      .NCH     (NCH),
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
   ) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_wr   (i_wr),
      .i_ch   (i_ch),
      .i_div  (i_div),
      .i_mode (i_mode),
      .i_step (i_step),
      .o_tick (o_tick),
      .o_clk  (o_clk),
      .o_busy (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Rising edges since reset release: the first edge with i_rst high is edge 1
   always @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit wr, input int ch, input int dv, input int md,
                        input logic [NCH-1:0] st,
                        output logic [NCH-1:0] tk, output logic [NCH-1:0] cl,
                        output logic [NCH-1:0] bs);
      i_wr   = wr;
      i_ch   = CH_W'(ch);
      i_div  = CNT_W'(dv);
      i_mode = 2'(md);
      i_step = st;
      @(posedge i_clk);
      #1;
      tk = o_tick;
      cl = o_clk;
      bs = o_busy;
      i_wr   = 1'b0;
      i_step = '0;
   endtask

   task automatic wait_tick(input logic [NCH-1:0] mask, input int bound, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(posedge i_clk);
         #1;
         if ((o_tick & mask) != '0) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: no tick within %0d cycles", name, bound);
      end
   endtask

   // Reference model: tick positions derived from elapsed cycles since the last write
   typedef struct {
      int d;
      int m;
      int wedge;
      int send;
      bit clk;
   } mch_t;

   mch_t mdl [NCH];

   task automatic model_edge(input int c, input int n, input bit hit, input int d, input int m,
                             input bit st, output bit etk, output bit ebs);
      int k;
      etk = 1'b0;
      ebs = 1'b0;
      if (hit) begin
         mdl[c].d     = d;
         mdl[c].m     = m;
         mdl[c].wedge = n;
         mdl[c].send  = -1;
         return;
      end
      if (mdl[c].d == 0) return;
      if (mdl[c].m == 1) begin
         k   = (n - mdl[c].wedge) % mdl[c].d;
         etk = (k == 0);
         ebs = (k != 0);
      end else if (mdl[c].m == 2) begin
         if (!(mdl[c].send >= 0 && n <= mdl[c].send) && st)
            mdl[c].send = n + mdl[c].d - 1;
         if (mdl[c].send >= 0 && n <= mdl[c].send) begin
            etk = (n == mdl[c].send);
            ebs = (n < mdl[c].send);
         end
      end
      if (etk) mdl[c].clk = !mdl[c].clk;
   endtask

   typedef struct {
      int ch;
      int dv;
      int md;
      int cycles;
      int exp_ticks;
      int exp_toggles;
      int exp_busy;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [NCH-1:0] tk, cl, bs;
      logic [9:0]     m35;
      logic [7:0]     st36, tk36, bs36;
      logic [10:0]    m37;
      int             ticks, toggles, busies;
      logic           prev;
      logic [NCH-1:0] etk_v, ecl_v, ebs_v;
      bit             etk, ebs;
      bit             wr;
      int             ch, dv, md;
      logic [NCH-1:0] st;

      tbl[0] = '{1, 3,     1, 30,  10, 10, 20};
      tbl[1] = '{1, 0,     1, 100, 0,  0,  0};
      tbl[2] = '{1, 1,     1, 20,  20, 20, 0};
      tbl[3] = '{0, 5,     0, 40,  0,  0,  0};
      tbl[4] = '{2, 7,     1, 70,  10, 10, 60};
      tbl[5] = '{0, 4,     2, 40,  0,  0,  0};
      tbl[6] = '{1, 2,     3, 20,  0,  0,  0};
      tbl[7] = '{2, 65535, 1, 200, 0,  0,  200};
      tbl[8] = '{0, 2,     1, 21,  10, 10, 11};

      i_rst = 1'b0; i_wr = 1'b0; i_ch = '0; i_div = '0; i_mode = '0; i_step = '0;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_tick", o_tick, 0);
      check("reset_clk",  o_clk,  0);
      check("reset_busy", o_busy, 0);

      // Default divisor after release; two synchroniser edges precede the first count
      @(negedge i_clk);
      i_rst = 1'b1;
      wait_tick(3'b001, 3000, "first_tick");
      check("first_tick_cycle", cyc, DIV_RST + 2);
      check("first_tick_all", o_tick, 3'b111);
      check("first_tick_clk", o_clk, 3'b111);
      wait_tick(3'b001, 2600, "second_tick");
      check("second_tick_cycle", cyc, 2 * DIV_RST + 2);
      check("second_tick_clk", o_clk, 3'b000);

      // ch1 to div=3 RUN; ch0 keeps its phase
      for (int i = 0; i < 10; i++) begin
         drive(i == 0, 1, 3, MODE_RUN, '0, tk, cl, bs);
         m35[i] = tk[1];
      end
      check("ch1_div3_ticks", m35, 10'h248);
      wait_tick(3'b001, 2600, "ch0_phase");
      check("ch0_phase_cycle", cyc, 3 * DIV_RST + 2);
      check("ch2_phase_tick", o_tick[2], 1'b1);

      foreach (tbl[v]) begin
         drive(1'b1, tbl[v].ch, tbl[v].dv, tbl[v].md, '0, tk, cl, bs);
         prev    = cl[tbl[v].ch];
         ticks   = 0;
         toggles = 0;
         busies  = 0;
         for (int i = 0; i < tbl[v].cycles; i++) begin
            drive(1'b0, 0, 0, 0, '0, tk, cl, bs);
            ticks  += int'(tk[tbl[v].ch]);
            busies += int'(bs[tbl[v].ch]);
            if (cl[tbl[v].ch] != prev) toggles++;
            prev = cl[tbl[v].ch];
         end
         check($sformatf("tbl%0d_ticks", v),   ticks,   tbl[v].exp_ticks);
         check($sformatf("tbl%0d_toggles", v), toggles, tbl[v].exp_toggles);
         check($sformatf("tbl%0d_busy", v),    busies,  tbl[v].exp_busy);
      end

      // STEP div=4: steps at offsets 0,1,3 -> only the first starts a count
      drive(1'b1, 0, 4, MODE_STEP, '0, tk, cl, bs);
      prev    = cl[0];
      toggles = 0;
      st36    = 8'b0000_1011;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 0, 0, 0, {2'b00, st36[i]}, tk, cl, bs);
         tk36[i] = tk[0];
         bs36[i] = bs[0];
         if (cl[0] != prev) toggles++;
         prev = cl[0];
      end
      check("step_ticks", tk36, 8'h08);
      check("step_busy", bs36, 8'h07);
      check("step_toggles", toggles, 1);

      // Second write lands on the terminal-count edge of the first
      drive(1'b0, 0, 0, 0, '0, tk, cl, bs);
      prev    = cl[0];
      toggles = 0;
      for (int i = 0; i < 11; i++) begin
         drive(i == 0 || i == 5, 0, 5, MODE_RUN, '0, tk, cl, bs);
         m37[i] = tk[0];
         if (cl[0] != prev) toggles++;
         prev = cl[0];
      end
      check("wr_vs_term_ticks", m37, 11'h400);
      check("wr_vs_term_toggles", toggles, 1);

      // Reset mid-count, then an out-of-range write after release
      drive(1'b1, 0, 7, MODE_RUN, '0, tk, cl, bs);
      repeat (4) drive(1'b0, 0, 0, 0, '0, tk, cl, bs);
      check("midcount_busy", bs[0], 1'b1);
      i_rst = 1'b0;
      #1;
      check("async_rst_tick", o_tick, 0);
      check("async_rst_clk",  o_clk,  0);
      check("async_rst_busy", o_busy, 0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      repeat (2) drive(1'b0, 0, 0, 0, '0, tk, cl, bs);
      drive(1'b1, 3, 5, MODE_HALT, '0, tk, cl, bs);
      wait_tick(3'b111, 3000, "after_rst_tick");
      check("after_rst_cycle", cyc, DIV_RST + 2);
      check("after_rst_all", o_tick, 3'b111);

      // Randomized run against the reference model, starting from a fresh reset
      i_rst = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b1;
      repeat (2) drive(1'b0, 0, 0, 0, '0, tk, cl, bs);
      for (int c = 0; c < NCH; c++) mdl[c] = '{DIV_RST, 1, 2, -1, 1'b0};
      for (int n = 3; n < 4003; n++) begin
         wr = ($urandom_range(0, 9) == 0);
         ch = $urandom_range(0, 3);
         dv = ($urandom_range(0, 15) == 0) ? $urandom_range(7, 40) : $urandom_range(0, 6);
         md = $urandom_range(0, 3);
         st = NCH'($urandom_range(0, 7));
         drive(wr, ch, dv, md, st, tk, cl, bs);
         for (int c = 0; c < NCH; c++) begin
            model_edge(c, n, wr && (ch == c), dv, md, st[c], etk, ebs);
            etk_v[c] = etk;
            ebs_v[c] = ebs;
            ecl_v[c] = mdl[c].clk;
         end
         check($sformatf("rand_tick@%0d", n), tk, etk_v);
         check($sformatf("rand_clk@%0d", n),  cl, ecl_v);
         check($sformatf("rand_busy@%0d", n), bs, ebs_v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
